// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared encodings for the EXE-stage multiply/divide sequencer.
//   MD_* op codes match the 2-bit op field driven by EXE:
//     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Bit 1 selects divide and bit 0 selects signed arithmetic.
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'b00,
      MD_RUN   = 2'b01,
      MD_FIXUP = 2'b10,
      MD_DONE  = 2'b11
   } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//   One radix-2 iteration of the multiply/divide loop. This block is purely
//   combinational; the sequencer registers the result.
//   Ports:
//     i_acc  : {hi, lo} accumulator (2*XLEN)
//     i_opnd : multiplicand or divisor magnitude (XLEN)
//     i_div  : 0 = shift-add multiply, 1 = restoring divide
//     o_acc  : accumulator after this step
//   Multiply: the multiplier sits in lo and is consumed LSB first. The
//     partial sum is built in hi, and the carry is shifted back into hi.
//   Divide: the dividend sits in lo and is consumed MSB first. The remainder
//     sits in hi, and quotient bits shift into lo from the right.
// ---------------------------------------------------------------------------
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_opnd,
   input  logic              i_div,
   output logic [2*XLEN-1:0] o_acc
);

   logic [XLEN-1:0]   w_hi;
   logic [XLEN-1:0]   w_lo;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_mul_acc;
   logic [XLEN:0]     w_trial;
   logic              w_ge;
   logic [XLEN-1:0]   w_diff;
   logic [2*XLEN-1:0] w_div_acc;

   assign w_hi = i_acc[2*XLEN-1:XLEN];
   assign w_lo = i_acc[XLEN-1:0];

   // Keep the carry out of the add so that full-range unsigned products are exact.
   assign w_sum     = {1'b0, w_hi} + {1'b0, i_opnd};
   assign w_mul_acc = w_lo[0] ? {w_sum, w_lo[XLEN-1:1]}
                              : {1'b0, w_hi, w_lo[XLEN-1:1]};

   // The shifted remainder needs XLEN+1 bits. Because rem < divisor before
   // the shift, any successful subtract fits back into XLEN bits.
   assign w_trial   = {w_hi, w_lo[XLEN-1]};
   assign w_ge      = (w_trial >= {1'b0, i_opnd});
   assign w_diff    = w_trial[XLEN-1:0] - i_opnd;
   assign w_div_acc = w_ge ? {w_diff,             w_lo[XLEN-2:0], 1'b1}
                           : {w_trial[XLEN-1:0],  w_lo[XLEN-2:0], 1'b0};

   assign o_acc = i_div ? w_div_acc : w_mul_acc;

endmodule

// File: rtl/exe_muldiv_seq.sv
// ---------------------------------------------------------------------------
// exe_muldiv_seq
//   Iterative MULT/MULTU/DIV/DIVU sequencer beside the EXE ALU.
//   The loop works on operand magnitudes for ITER cycles. One FIXUP cycle
//   then restores the signs, and DONE pulses for one cycle.
//   Ports:
//     clk, rst     : clock and asynchronous active-low reset
//     start, op    : request and operation (MD_* encoding)
//     Val1, Val2   : rs and rt operands, captured on the accept edge
//     flush        : aborts the operation in flight (wins over start)
//     stall        : holds IF/ID/EXE while the operation is outstanding
//     busy         : high in RUN or FIXUP
//     done         : one-cycle result-valid pulse
//     hi_out       : product upper half, or remainder
//     lo_out       : product lower half, or quotient
//     div_by_zero  : set by a divide with a zero divisor; cleared by the
//                    next accepted operation
// ---------------------------------------------------------------------------
module exe_muldiv_seq
   import mips_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] Val1,
   input  logic [XLEN-1:0] Val2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi_out,
   output logic [XLEN-1:0] lo_out,
   output logic            div_by_zero
);

   localparam int             CW       = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(ITER - 1);

   md_state_e         r_state;
   logic [1:0]        r_op;
   logic              r_s1;
   logic              r_s2;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_acc;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_done;
   logic              r_dbz;

   logic              w_accept;
   logic              w_s1;
   logic              w_s2;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic              w_div0;
   logic [2*XLEN-1:0] w_step_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_hi;
   logic [XLEN-1:0]   w_fix_lo;

   assign w_accept = start && !flush && (r_state == MD_IDLE || r_state == MD_DONE);

   // Signs are captured only for signed ops, so FIXUP does not need to
   // check op again to leave unsigned results alone.
   assign w_s1   = op[0] & Val1[XLEN-1];
   assign w_s2   = op[0] & Val2[XLEN-1];
   // The magnitude is read back as unsigned, so 0x80000000 stays exact.
   assign w_abs1 = w_s1 ? -Val1 : Val1;
   assign w_abs2 = w_s2 ? -Val2 : Val2;
   assign w_div0 = op[1] && (Val2 == '0);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_div  (r_op[1]),
      .o_acc  (w_step_acc)
   );

   // Sign restoration. The remainder follows the dividend. The quotient
   // of MIN / -1 wraps back to MIN, which is the architected result.
   assign w_prod = (r_op == MD_MULT && (r_s1 ^ r_s2)) ? -r_acc : r_acc;
   assign w_quot = (r_op == MD_DIV && (r_s1 ^ r_s2)) ? -r_acc[XLEN-1:0]
                                                    : r_acc[XLEN-1:0];
   assign w_rem  = (r_op == MD_DIV && r_s1) ? -r_acc[2*XLEN-1:XLEN]
                                           : r_acc[2*XLEN-1:XLEN];

   assign w_fix_hi = r_op[1] ? w_rem  : w_prod[2*XLEN-1:XLEN];
   assign w_fix_lo = r_op[1] ? w_quot : w_prod[XLEN-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MD_IDLE;
         r_op    <= MD_MULTU;
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_opnd  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else if (flush) begin
         // Abort the operation in flight. The architected HI/LO and the
         // divide-by-zero flag keep their values.
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            MD_IDLE, MD_DONE: begin
               if (start) begin
                  r_op <= op;
                  if (w_div0) begin
                     r_hi    <= Val1;
                     r_lo    <= '1;
                     r_dbz   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= MD_DONE;
                  end else begin
                     r_s1    <= w_s1;
                     r_s2    <= w_s2;
                     r_opnd  <= w_abs2;
                     r_acc   <= {{XLEN{1'b0}}, w_abs1};
                     r_cnt   <= CNT_LOAD;
                     r_dbz   <= 1'b0;
                     r_state <= MD_RUN;
                  end
               end else begin
                  r_state <= MD_IDLE;
               end
            end
            MD_RUN: begin
               r_acc <= w_step_acc;
               if (r_cnt == '0) begin
                  r_state <= MD_FIXUP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            MD_FIXUP: begin
               r_hi    <= w_fix_hi;
               r_lo    <= w_fix_lo;
               r_done  <= 1'b1;
               r_state <= MD_DONE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   // The accept term makes stall rise in the issuing cycle itself.
   assign stall       = (r_state == MD_RUN) || (r_state == MD_FIXUP) || w_accept;
   assign busy        = (r_state == MD_RUN) || (r_state == MD_FIXUP);
   assign done        = r_done;
   assign hi_out      = r_hi;
   assign lo_out      = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
module tb_exe_muldiv_seq;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 2;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      op = 2'b00;
   logic [XLEN-1:0] Val1 = '0;
   logic [XLEN-1:0] Val2 = '0;
   logic            flush = 1'b0;
   logic            stall, busy, done, div_by_zero;
   logic [XLEN-1:0] hi_out, lo_out;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string           tag;
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic            dbz;
      int              lat;
   } exp_t;

   exp_t sb[$];

   exe_muldiv_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .Val1(Val1), .Val2(Val2),
      .flush(flush), .stall(stall), .busy(busy), .done(done),
      .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model built from native operators. It is independent of
   // the iterative datapath.
   function automatic exp_t model(input string tag, input logic [1:0] o,
                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      exp_t   e;
      longint sa, sb_, r64;
      logic [63:0] p;
      e.tag = tag; e.dbz = 1'b0; e.lat = LAT;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      if (o[1] && b == '0) begin
         e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
      end else begin
         case (o)
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MULT:  begin r64 = sa * sb_; p = r64; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_DIVU:  begin e.lo = a / b; e.hi = a % b; end
            default:  begin r64 = sa / sb_; p = r64; e.lo = p[31:0];
                            r64 = sa % sb_; p = r64; e.hi = p[31:0]; end
         endcase
      end
      return e;
   endfunction

   task automatic expect_res(input string tag, input logic [XLEN-1:0] h,
                             input logic [XLEN-1:0] l, input logic d, input int lat);
      exp_t e;
      e.tag = tag; e.hi = h; e.lo = l; e.dbz = d; e.lat = lat;
      sb.push_back(e);
   endtask

   // The caller is at a negedge. This task drives the request, checks the
   // combinational stall, and passes the accept edge. It then scrambles the
   // operands, which must have no effect.
   task automatic launch(input string tag, input logic [1:0] o,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      start = 1'b1; op = o; Val1 = a; Val2 = b;
      #1;
      chk({tag, " stall@accept"}, 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0; op = 2'($urandom); Val1 = $urandom; Val2 = $urandom;
   endtask

   // This task counts cycles after the accept edge until done is seen. It
   // checks stall/busy on every cycle, then compares the result with the
   // scoreboard head. It returns at the negedge of the done cycle.
   task automatic wait_done(input string tag);
      int   lat;
      logic ok;
      exp_t e;
      lat = -1; ok = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            if (stall || busy) ok = 1'b0;
            break;
         end
         if (!stall) ok = 1'b0;
         if (!busy && k > 1) ok = 1'b0;
      end
      if (sb.size() == 0) begin
         chk({tag, " scoreboard"}, 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, " latency"}, 64'(lat), 64'(e.lat));
      chk({tag, " stall/busy"}, 64'(ok), 64'd1);
      if (lat > 0) begin
         chk({tag, " hi"}, 64'(hi_out), 64'(e.hi));
         chk({tag, " lo"}, 64'(lo_out), 64'(e.lo));
         chk({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
      end
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] h,
                      input logic [XLEN-1:0] l, input logic d);
      @(negedge clk);
      expect_res(tag, h, l, d, (o[1] && b == '0) ? 1 : LAT);
      launch(tag, o, a, b);
      wait_done(tag);
      @(negedge clk);
      chk({tag, " done pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      exp_t e;
      logic seen;

      // Reset state
      #1;
      chk("rst hi", 64'(hi_out), 64'd0);
      chk("rst lo", 64'(lo_out), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst dbz", 64'(div_by_zero), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst stall", 64'(stall), 64'd0);
      @(negedge clk); rst = 1'b1;

      // Directed arithmetic
      run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      run("divu_zero", OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
      run("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run("div_zero_s", OP_DIV,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);

      // Pseudo-random operands checked against the model
      for (int i = 0; i < 6; i++) begin
         logic [1:0]      ro;
         logic [XLEN-1:0] ra, rb;
         ro = 2'(i % 4); ra = $urandom; rb = $urandom;
         if (i >= 4) rb = rb >> 20;
         e = model("rand", ro, ra, rb);
         run("rand", ro, ra, rb, e.hi, e.lo, e.dbz);
      end

      // Set HI/LO to 0x11/0x22, then flush a multiply mid-RUN
      run("divu_prep", OP_DIVU, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0);
      @(negedge clk);
      launch("flush", OP_MULTU, 32'd3, 32'd4);
      repeat (9) @(negedge clk);   // negedge of cycle 10
      flush = 1'b1; start = 1'b1; op = OP_MULTU; Val1 = 32'd5; Val2 = 32'd6;
      @(negedge clk);              // cycle 11: IDLE with flush and start both high
      chk("flush stall", 64'(stall), 64'd0);
      chk("flush busy", 64'(busy), 64'd0);
      chk("flush hi", 64'(hi_out), 64'h11);
      chk("flush lo", 64'(lo_out), 64'h22);
      @(negedge clk);
      chk("flush prio", 64'(busy), 64'd0);
      flush = 1'b0; start = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("flush no done", 64'(seen), 64'd0);

      // Back-to-back: start the next op in the DONE cycle
      @(negedge clk);
      expect_res("b2b_a", 32'd0, 32'd12, 1'b0, LAT);
      launch("b2b_a", OP_MULTU, 32'd3, 32'd4);
      wait_done("b2b_a");
      expect_res("b2b_b", 32'd1, 32'hFFFFFFFD, 1'b0, LAT);
      launch("b2b_b", OP_DIV, 32'd7, 32'hFFFFFFFE);
      wait_done("b2b_b");
      @(negedge clk);
      chk("b2b done pulse", 64'(done), 64'd0);

      // Asynchronous reset during RUN
      run("dbz_prep", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      @(negedge clk);
      launch("rst_run", OP_MULTU, 32'd6, 32'd7);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstrun hi", 64'(hi_out), 64'd0);
      chk("rstrun lo", 64'(lo_out), 64'd0);
      chk("rstrun dbz", 64'(div_by_zero), 64'd0);
      chk("rstrun busy", 64'(busy), 64'd0);
      chk("rstrun stall", 64'(stall), 64'd0);
      chk("rstrun done", 64'(done), 64'd0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("sb empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
